// File: rtl/coincidence_histogram_scanner_if.sv
// Recorder CSR command/readback bundle between the histogram scanner and the coincidence recorder.
interface coincidence_histogram_scanner_if;
  logic        recCsrStrobe;
  logic [31:0] recGPIO_OUT;
  logic [31:0] recCsr;

  modport master (output recCsrStrobe, output recGPIO_OUT, input recCsr);
  modport slave  (input recCsrStrobe, input recGPIO_OUT, output recCsr);
endinterface

// File: rtl/coincidence_histogram_scanner.sv
// Arms one recorder acquisition, reads back every histogram bin per channel and records the threshold-crossing edge.
// Optional SCAN_AUTO_ALIGN_EN: after the scan, re-centre the coincidence window on channel 0's edge plus an offset.
module coincidence_histogram_scanner #(
  parameter int CHANNEL_COUNT               = 2,
  parameter int SAMPLE_CLKS_PER_COINCIDENCE = 80,
  parameter int SUM_WIDTH                   = 10,
  parameter int SETTLE_CYCLES               = 4,
  parameter int TIMEOUT_CYCLES              = 1000000,
  localparam int AW = $clog2(SAMPLE_CLKS_PER_COINCIDENCE),
  localparam int MW = $clog2(CHANNEL_COUNT),
  localparam int CW = (MW > 0) ? MW : 1
) (
  input  logic                 sysClk,
  input  logic                 sysReset_n,
  input  logic                 scanStart,
  input  logic [SUM_WIDTH-1:0] scanThreshold,
  coincidence_histogram_scanner_if.master rec,
  output logic                 scanBusy,
  output logic                 scanDone,
  output logic                 scanError,
  input  logic [CW-1:0]        resultSel,
  output logic [AW-1:0]        resultEdge,
  output logic                 resultValid,
  output logic [2:0]           resultEdgeCount
`ifdef SCAN_AUTO_ALIGN_EN
  ,
  input  logic [AW-1:0]        alignOffset,
  input  logic                 alignEnable
`endif
);

  localparam int N  = SAMPLE_CLKS_PER_COINCIDENCE;
  localparam int IW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(N - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N);
  localparam logic [CW-1:0] CH_LAST     = CW'(CHANNEL_COUNT - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT_BUSY_HI, S_WAIT_BUSY_LO, S_ISSUE, S_WAIT_RB,
    S_PROCESS, S_DONE, S_ERROR
`ifdef SCAN_AUTO_ALIGN_EN
    , S_SET_COINC, S_REALIGN
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [SUM_WIDTH-1:0] prev_q, prev_d, cur_q, cur_d, thr_q, thr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic                 matched_q, matched_d;
  logic                 strobe_q, strobe_d;
  logic [31:0]          gpio_q, gpio_d;
  logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [AW-1:0]        edge_addr_q [CHANNEL_COUNT];
  logic [AW-1:0]        edge_addr_d [CHANNEL_COUNT];
  logic                 valid_q [CHANNEL_COUNT];
  logic                 valid_d [CHANNEL_COUNT];
  logic [2:0]           cnt_q [CHANNEL_COUNT];
  logic [2:0]           cnt_d [CHANNEL_COUNT];
  logic [AW-1:0]        res_edge_q, res_edge_d;
  logic                 res_valid_q, res_valid_d;
  logic [2:0]           res_cnt_q, res_cnt_d;
  logic [AW-1:0]        cur_addr;
  logic                 rb_match;
  logic                 crossing;
  state_t               finish_state;
  logic                 unused_rb;

  // idx 0 reads the last bin first so the wrap from bin N-1 to bin 0 is seen as a normal step.
  assign cur_addr  = (idx_q == '0) ? LAST_ADDR : AW'(idx_q - 1'b1);
  assign rb_match  = (rec.recCsr[24 +: CW] == ch_q) && (rec.recCsr[SUM_WIDTH +: AW] == cur_addr);
  assign unused_rb = ^rec.recCsr;

`ifdef SCAN_AUTO_ALIGN_EN
  logic [AW:0]   align_sum;
  logic [AW-1:0] align_addr;
  assign align_sum  = {1'b0, edge_addr_q[0]} + {1'b0, alignOffset};
  assign align_addr = (align_sum >= (AW+1)'(N)) ? AW'(align_sum - (AW+1)'(N)) : align_sum[AW-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    thr_d       = thr_q;
    timer_d     = timer_q;
    settle_d    = settle_q;
    matched_d   = matched_q;
    strobe_d    = 1'b0;
    gpio_d      = '0;
    error_d     = error_q;
    edge_addr_d = edge_addr_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    crossing    = 1'b0;
`ifdef SCAN_AUTO_ALIGN_EN
    finish_state = (alignEnable && valid_d[0]) ? S_SET_COINC : S_DONE;
`else
    finish_state = S_DONE;
`endif

    case (state_q)
      S_IDLE: begin
        if (scanStart) begin
          error_d = 1'b0;
          thr_d   = scanThreshold;
          for (int i = 0; i < CHANNEL_COUNT; i++) begin
            edge_addr_d[i] = '0;
            valid_d[i]     = 1'b0;
            cnt_d[i]       = '0;
          end
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        strobe_d   = 1'b1;
        gpio_d[31] = 1'b1;
        timer_d    = '0;
        state_d    = S_WAIT_BUSY_HI;
      end
      S_WAIT_BUSY_HI: begin
        if (rec.recCsr[31]) begin
          timer_d = '0;
          state_d = S_WAIT_BUSY_LO;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_BUSY_LO: begin
        if (!rec.recCsr[31]) begin
          ch_d    = '0;
          idx_d   = '0;
          state_d = S_ISSUE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ISSUE: begin
        strobe_d           = 1'b1;
        gpio_d[24 +: CW]   = ch_q;
        gpio_d[0 +: AW]    = cur_addr;
        timer_d            = '0;
        settle_d           = '0;
        matched_d          = 1'b0;
        state_d            = S_WAIT_RB;
      end
      S_WAIT_RB: begin
        // The timeout covers only the wait for the address match; settling is bounded by itself.
        if (!matched_q) begin
          if (rb_match) begin
            matched_d = 1'b1;
          end else if (timer_q == TIMER_LAST) begin
            state_d = S_ERROR;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else if (settle_q == SETTLE_LAST) begin
          cur_d   = rec.recCsr[SUM_WIDTH-1:0];
          state_d = S_PROCESS;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_PROCESS: begin
        if (idx_q != '0) begin
          crossing = (prev_q < thr_q) && (cur_q >= thr_q);
          if (crossing) begin
            if (!valid_q[ch_q]) begin
              edge_addr_d[ch_q] = cur_addr;
              valid_d[ch_q]     = 1'b1;
            end
            if (cnt_q[ch_q] != 3'd7) cnt_d[ch_q] = cnt_q[ch_q] + 3'd1;
          end
        end
        prev_d = cur_q;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (ch_q == CH_LAST) begin
            state_d = finish_state;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
`ifdef SCAN_AUTO_ALIGN_EN
      S_SET_COINC: begin
        strobe_d        = 1'b1;
        gpio_d[30]      = 1'b1;
        gpio_d[0 +: AW] = align_addr;
        state_d         = S_REALIGN;
      end
      S_REALIGN: begin
        strobe_d   = 1'b1;
        gpio_d[29] = 1'b1;
        state_d    = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERROR) error_d = 1'b1;
    busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    done_d = (state_d == S_DONE);

    res_edge_d  = '0;
    res_valid_d = 1'b0;
    res_cnt_d   = '0;
    if (32'(resultSel) < CHANNEL_COUNT) begin
      res_edge_d  = edge_addr_q[resultSel];
      res_valid_d = valid_q[resultSel];
      res_cnt_d   = cnt_q[resultSel];
    end
  end

  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      idx_q       <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      thr_q       <= '0;
      timer_q     <= '0;
      settle_q    <= '0;
      matched_q   <= 1'b0;
      strobe_q    <= 1'b0;
      gpio_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      res_edge_q  <= '0;
      res_valid_q <= 1'b0;
      res_cnt_q   <= '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        edge_addr_q[i] <= '0;
        valid_q[i]     <= 1'b0;
        cnt_q[i]       <= '0;
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      idx_q       <= idx_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      thr_q       <= thr_d;
      timer_q     <= timer_d;
      settle_q    <= settle_d;
      matched_q   <= matched_d;
      strobe_q    <= strobe_d;
      gpio_q      <= gpio_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      res_edge_q  <= res_edge_d;
      res_valid_q <= res_valid_d;
      res_cnt_q   <= res_cnt_d;
      edge_addr_q <= edge_addr_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rec.recCsrStrobe = strobe_q;
  assign rec.recGPIO_OUT  = gpio_q;
  assign scanBusy         = busy_q;
  assign scanDone         = done_q;
  assign scanError        = error_q;
  assign resultEdge       = res_edge_q;
  assign resultValid      = res_valid_q;
  assign resultEdgeCount  = res_cnt_q;

endmodule

// File: tb/tb_coincidence_histogram_scanner.sv
// Directed bench for coincidence_histogram_scanner with a behavioural coincidence recorder model.
module tb_coincidence_histogram_scanner;
  localparam int CH  = 2;
  localparam int N   = 80;
  localparam int TMO = 300;

  logic       sysClk = 1'b0;
  logic       sysReset_n = 1'b0;
  logic       scanStart = 1'b0;
  logic [9:0] scanThreshold = '0;
  logic [0:0] resultSel = '0;
  logic       scanBusy, scanDone, scanError;
  logic [6:0] resultEdge;
  logic       resultValid;
  logic [2:0] resultEdgeCount;
`ifdef SCAN_AUTO_ALIGN_EN
  logic [6:0] alignOffset = '0;
  logic       alignEnable = 1'b0;
`endif

  coincidence_histogram_scanner_if bus();

  coincidence_histogram_scanner #(
    .CHANNEL_COUNT(CH), .SAMPLE_CLKS_PER_COINCIDENCE(N), .SUM_WIDTH(10),
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .scanStart(scanStart),
    .scanThreshold(scanThreshold), .rec(bus), .scanBusy(scanBusy),
    .scanDone(scanDone), .scanError(scanError), .resultSel(resultSel),
    .resultEdge(resultEdge), .resultValid(resultValid), .resultEdgeCount(resultEdgeCount)
`ifdef SCAN_AUTO_ALIGN_EN
    , .alignOffset(alignOffset), .alignEnable(alignEnable)
`endif
  );

  always #5 sysClk = ~sysClk;

  // Recorder model: busy pulse after ARM; readback address appears before its sum does.
  logic [9:0] hist [CH][N];
  bit         busy_never = 1'b0;
  int         arm_age = -1, pend_age = -1;
  logic [0:0] pend_ch = '0, rb_mux = '0;
  logic [6:0] pend_addr = '0, rb_addr = '0;
  logic [9:0] rb_sum = '0;
  logic       rec_busy;
  int cyc = 0, arm_cnt = 0, done_cnt = 0, total_strobes = 0;
  int read_cnt [CH] = '{0, 0};
  int coinc_cnt = 0, realign_cnt = 0, coinc_val = 0, coinc_cyc = 0, realign_cyc = 0, done_cyc = 0;

  assign rec_busy = (arm_age >= 3) && (arm_age < 13) && !busy_never;

  always_comb begin
    bus.recCsr = '0;
    bus.recCsr[31] = rec_busy;
    bus.recCsr[24] = rb_mux;
    bus.recCsr[10 +: 7] = rb_addr;
    bus.recCsr[0 +: 10] = rb_sum;
  end

  always @(posedge sysClk) begin
    cyc <= cyc + 1;
    if (arm_age >= 0) arm_age <= (arm_age >= 13) ? -1 : arm_age + 1;
    if (pend_age >= 0) begin
      pend_age <= (pend_age >= 4) ? -1 : pend_age + 1;
      if (pend_age == 2) begin
        rb_mux  <= pend_ch;
        rb_addr <= pend_addr;
        rb_sum  <= 10'h155;
      end
      if (pend_age == 4) rb_sum <= hist[pend_ch][pend_addr];
    end
    if (bus.recCsrStrobe) begin
      total_strobes <= total_strobes + 1;
      if (bus.recGPIO_OUT[31]) begin
        arm_cnt <= arm_cnt + 1;
        arm_age <= 0;
      end else if (bus.recGPIO_OUT[30]) begin
        coinc_cnt <= coinc_cnt + 1;
        coinc_val <= int'(bus.recGPIO_OUT[6:0]);
        coinc_cyc <= cyc;
      end else if (bus.recGPIO_OUT[29]) begin
        realign_cnt <= realign_cnt + 1;
        realign_cyc <= cyc;
      end else begin
        read_cnt[bus.recGPIO_OUT[24]] <= read_cnt[bus.recGPIO_OUT[24]] + 1;
        pend_age  <= 0;
        pend_ch   <= bus.recGPIO_OUT[24];
        pend_addr <= bus.recGPIO_OUT[6:0];
      end
    end
    if (scanDone) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic start_scan(input logic [9:0] thr);
    scanThreshold = thr;
    scanStart = 1'b1;
    tick();
    scanStart = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (scanBusy && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_finished"}, scanBusy, 0);
    tick();
    tick();
  endtask

  task automatic expect_result(input string tag, input logic [0:0] sel,
                               input int e, input int v, input int c);
    resultSel = sel;
    tick();
    check({tag, "_edge"}, resultEdge, e);
    check({tag, "_valid"}, resultValid, v);
    check({tag, "_count"}, resultEdgeCount, c);
  endtask

  task automatic fill(input int ch, input int lo, input int hi, input logic [9:0] val);
    for (int k = lo; k <= hi; k++) hist[ch][k] = val;
  endtask

  int base_arm, base_r0, base_r1, base_done, base_str;

  initial begin
    fill(0, 0, 39, 10'd0);    fill(0, 40, 79, 10'd1023);
    fill(1, 0, 9, 10'd1023);  fill(1, 10, 69, 10'd0);  fill(1, 70, 79, 10'd1023);

    repeat (3) tick();
    check("rst_busy", scanBusy, 0);
    check("rst_done", scanDone, 0);
    check("rst_error", scanError, 0);
    check("rst_strobe", bus.recCsrStrobe, 0);
    check("rst_gpio", bus.recGPIO_OUT, 0);
    check("rst_edge", resultEdge, 0);
    check("rst_valid", resultValid, 0);
    sysReset_n = 1'b1;
    tick();

    // Scan 1: single step on ch0, wrapping step on ch1; second start mid-scan is ignored.
    base_arm = arm_cnt; base_r0 = read_cnt[0]; base_r1 = read_cnt[1]; base_done = done_cnt;
    start_scan(10'd512);
    check("s1_busy_after_start", scanBusy, 1);
    repeat (20) tick();
    scanStart = 1'b1; tick(); scanStart = 1'b0;
    wait_idle("s1", 5000);
    check("s1_arm_words", arm_cnt - base_arm, 1);
    check("s1_reads_ch0", read_cnt[0] - base_r0, 81);
    check("s1_reads_ch1", read_cnt[1] - base_r1, 81);
    check("s1_done_pulses", done_cnt - base_done, 1);
    check("s1_error", scanError, 0);
    expect_result("s1_ch0", 1'b0, 40, 1, 1);
    expect_result("s1_ch1", 1'b1, 70, 1, 1);

    // Timeout: recorder never goes busy.
    busy_never = 1'b1;
    base_done = done_cnt;
    start_scan(10'd512);
    repeat (20) tick();
    check("to_busy_waiting", scanBusy, 1);
    check("to_no_early_error", scanError, 0);
    wait_idle("to", 2000);
    check("to_error", scanError, 1);
    check("to_busy", scanBusy, 0);
    check("to_no_done", done_cnt - base_done, 0);
    expect_result("to_cleared", 1'b0, 0, 0, 0);
    busy_never = 1'b0;

    // Scan 2: two crossings on ch0, flat 500 on ch1.
    fill(0, 0, 19, 10'd0);  fill(0, 20, 39, 10'd1023);
    fill(0, 40, 59, 10'd0); fill(0, 60, 79, 10'd1023);
    fill(1, 0, 79, 10'd500);
    start_scan(10'd512);
    check("s2_error_cleared", scanError, 0);
    wait_idle("s2", 5000);
    expect_result("s2_ch0", 1'b0, 20, 1, 2);
    expect_result("s2_ch1", 1'b1, 0, 0, 0);

    // Scan 3: ten crossings on ch0 saturate the count.
    for (int k = 0; k < N; k++) hist[0][k] = ((k / 4) % 2 == 1) ? 10'd1023 : 10'd0;
    start_scan(10'd512);
    wait_idle("s3", 5000);
    expect_result("s3_ch0_sat", 1'b0, 4, 1, 7);

    // Scan 4: threshold zero can never be crossed.
    start_scan(10'd0);
    wait_idle("s4", 5000);
    expect_result("s4_thr0_ch0", 1'b0, 0, 0, 0);

    // Reset while waiting for a readback, after ch0 has already found its edge.
    fill(0, 0, 39, 10'd0); fill(0, 40, 79, 10'd1023);
    resultSel = 1'b0;
    base_r0 = read_cnt[0];
    start_scan(10'd512);
    for (int n = 0; n < 3000 && (read_cnt[0] - base_r0) < 50; n++) tick();
    check("rst_mid_reached", (read_cnt[0] - base_r0) >= 50, 1);
    sysReset_n = 1'b0;
    tick();
    check("rst_mid_busy", scanBusy, 0);
    check("rst_mid_strobe", bus.recCsrStrobe, 0);
    check("rst_mid_gpio", bus.recGPIO_OUT, 0);
    sysReset_n = 1'b1;
    base_str = total_strobes;
    tick();
    expect_result("rst_mid_ch0", 1'b0, 0, 0, 0);
    repeat (30) tick();
    check("rst_mid_no_cmds", total_strobes - base_str, 0);
    check("rst_mid_idle", scanBusy, 0);

`ifdef SCAN_AUTO_ALIGN_EN
    fill(0, 0, 74, 10'd0); fill(0, 75, 79, 10'd1023);
    alignEnable = 1'b1;
    alignOffset = 7'd10;
    base_done = done_cnt;
    start_scan(10'd512);
    wait_idle("al", 5000);
    check("al_coinc_words", coinc_cnt, 1);
    check("al_coinc_value", coinc_val, 5);
    check("al_realign_words", realign_cnt, 1);
    check("al_realign_next_cycle", realign_cyc - coinc_cyc, 1);
    check("al_done_after", done_cyc > realign_cyc, 1);
    check("al_done_pulses", done_cnt - base_done, 1);
    expect_result("al_ch0", 1'b0, 75, 1, 1);
`else
    check("no_coinc_words", coinc_cnt, 0);
    check("no_realign_words", realign_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "simulation time limit");
  end
endmodule
